// File: rtl/ws2812_frame_arbiter.sv
// rtl/ws2812_frame_arbiter.sv - refresh pacing and two-source frame arbitration for a WS2812 driver
module ws2812_frame_arbiter #(
  parameter int FRAME_DIV   = 833333,
  parameter int TIMEOUT     = 500000,
  parameter int N_LEDS      = 256,
  parameter bit S1_PRIORITY = 1'b1
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        frame_en,
  input  logic        clr_err,
  output logic        s0_frame_stb,
  input  logic [23:0] s0_led_data,
  input  logic        s0_valid,
  input  logic        s0_start,
  output logic        s0_done_bit,
  output logic        s0_done_dz,
  input  logic        s1_req,
  output logic        s1_frame_stb,
  input  logic [23:0] s1_led_data,
  input  logic        s1_valid,
  input  logic        s1_start,
  output logic        s1_done_bit,
  output logic        s1_done_dz,
  output logic [23:0] led_data,
  output logic        valid,
  output logic        start,
  input  logic        done_bit_in,
  input  logic        done_dz_in,
  output logic        busy,
  output logic        owner,
  output logic [7:0]  overrun_cnt,
  output logic        err_timeout,
  output logic        err_len
);

  localparam int SLOT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PIX_W  = $clog2(N_LEDS + 2);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(N_LEDS);
  localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(N_LEDS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SLOT_W-1:0] slot_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic              slot;
  logic              in_run;
  logic              done_evt;
  logic              to_evt;
  logic              ovr_evt;

  // Slot pacing: free-running refresh timer, held at zero while disabled
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (!frame_en || slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign slot     = frame_en && (slot_cnt == SLOT_LAST);
  assign in_run   = (state == S_RUN);
  // Completion takes precedence when it lands on the timeout cycle
  assign done_evt = in_run && done_dz_in;
  assign to_evt   = in_run && !done_dz_in && (to_cnt == TO_LAST);
  // A slot arriving while a frame is still granted or in flight is dropped
  assign ovr_evt  = slot && (state != S_IDLE);

  // FSM state register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: one whole frame per accepted slot
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (slot) state_next = S_GRANT;
      S_GRANT: state_next = S_RUN;
      S_RUN:   if (done_evt || to_evt) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: grant strobes, driver mux and done routing to the owner only
  always_comb begin
    busy         = (state != S_IDLE);
    s0_frame_stb = (state == S_GRANT) && !owner;
    s1_frame_stb = (state == S_GRANT) && owner;
    led_data     = '0;
    valid        = 1'b0;
    start        = 1'b0;
    if (in_run && !to_evt) begin
      led_data = owner ? s1_led_data : s0_led_data;
      valid    = owner ? s1_valid    : s0_valid;
      start    = owner ? s1_start    : s0_start;
    end
    s0_done_bit = in_run && !owner && done_bit_in;
    s0_done_dz  = in_run && !owner && done_dz_in;
    s1_done_bit = in_run && owner && done_bit_in;
    s1_done_dz  = in_run && owner && done_dz_in;
  end

  // Owner latch: source 1 only wins a slot when its request is visible at that slot
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 1'b0;
    end else if (state == S_IDLE && slot) begin
      owner <= s1_req && (S1_PRIORITY || !frame_en);
    end
  end

  // Per-frame pixel and timeout counters, cleared during the grant cycle
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      pix_cnt <= '0;
    end else if (state == S_GRANT) begin
      to_cnt  <= '0;
      pix_cnt <= '0;
    end else if (in_run) begin
      if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
      if (done_bit_in && pix_cnt != PIX_SAT) pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Sticky errors: a new error in the same cycle as clr_err survives the clear
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (done_evt && pix_cnt != PIX_FULL) err_len <= 1'b1;
      else if (clr_err)                    err_len <= 1'b0;
      if (to_evt)       err_timeout <= 1'b1;
      else if (clr_err) err_timeout <= 1'b0;
    end
  end

  // Dropped-slot counter, saturating; clear plus overrun in one cycle leaves 1
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= 8'd0;
    end else if (ovr_evt) begin
      if (clr_err)                  overrun_cnt <= 8'd1;
      else if (overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end else if (clr_err) begin
      overrun_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// tb/tb_ws2812_frame_arbiter.sv - directed self-checking bench for ws2812_frame_arbiter
module tb_ws2812_frame_arbiter;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        frame_en;
  logic        clr_err;
  logic [23:0] s0_led_data;
  logic        s0_valid;
  logic        s0_start;
  logic        s1_req;
  logic [23:0] s1_led_data;
  logic        s1_valid;
  logic        s1_start;
  logic        done_bit_in;
  logic        done_dz_in;

  logic        a_s0_frame_stb, a_s0_done_bit, a_s0_done_dz;
  logic        a_s1_frame_stb, a_s1_done_bit, a_s1_done_dz;
  logic [23:0] a_led_data;
  logic        a_valid, a_start, a_busy, a_owner, a_err_timeout, a_err_len;
  logic [7:0]  a_overrun_cnt;

  logic        b_s0_frame_stb, b_s0_done_bit, b_s0_done_dz;
  logic        b_s1_frame_stb, b_s1_done_bit, b_s1_done_dz;
  logic [23:0] b_led_data;
  logic        b_valid, b_start, b_busy, b_owner, b_err_timeout, b_err_len;
  logic [7:0]  b_overrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int g;
  int n;

  always #5 clk_50m = ~clk_50m;

  ws2812_frame_arbiter #(.FRAME_DIV(100), .TIMEOUT(60), .N_LEDS(4), .S1_PRIORITY(1'b1)) dut_a (
    .clk_50m(clk_50m), .rst_n(rst_n), .frame_en(frame_en), .clr_err(clr_err),
    .s0_frame_stb(a_s0_frame_stb), .s0_led_data(s0_led_data), .s0_valid(s0_valid), .s0_start(s0_start),
    .s0_done_bit(a_s0_done_bit), .s0_done_dz(a_s0_done_dz),
    .s1_req(s1_req), .s1_frame_stb(a_s1_frame_stb), .s1_led_data(s1_led_data), .s1_valid(s1_valid),
    .s1_start(s1_start), .s1_done_bit(a_s1_done_bit), .s1_done_dz(a_s1_done_dz),
    .led_data(a_led_data), .valid(a_valid), .start(a_start),
    .done_bit_in(done_bit_in), .done_dz_in(done_dz_in),
    .busy(a_busy), .owner(a_owner), .overrun_cnt(a_overrun_cnt),
    .err_timeout(a_err_timeout), .err_len(a_err_len)
  );

  ws2812_frame_arbiter #(.FRAME_DIV(100), .TIMEOUT(200), .N_LEDS(4), .S1_PRIORITY(1'b0)) dut_b (
    .clk_50m(clk_50m), .rst_n(rst_n), .frame_en(frame_en), .clr_err(clr_err),
    .s0_frame_stb(b_s0_frame_stb), .s0_led_data(s0_led_data), .s0_valid(s0_valid), .s0_start(s0_start),
    .s0_done_bit(b_s0_done_bit), .s0_done_dz(b_s0_done_dz),
    .s1_req(s1_req), .s1_frame_stb(b_s1_frame_stb), .s1_led_data(s1_led_data), .s1_valid(s1_valid),
    .s1_start(s1_start), .s1_done_bit(b_s1_done_bit), .s1_done_dz(b_s1_done_dz),
    .led_data(b_led_data), .valid(b_valid), .start(b_start),
    .done_bit_in(done_bit_in), .done_dz_in(done_dz_in),
    .busy(b_busy), .owner(b_owner), .overrun_cnt(b_overrun_cnt),
    .err_timeout(b_err_timeout), .err_len(b_err_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk_50m);
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wait_stb(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!(a_s0_frame_stb || a_s1_frame_stb) && cnt < 400);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  task automatic run_frame(input logic own, input int npix, input logic [23:0] exp_data, input logic exp_start);
    step(1);
    chk("run_valid", a_valid, 1'b1);
    chk("run_data", a_led_data, exp_data);
    chk("run_start", a_start, exp_start);
    for (int i = 0; i < npix; i++) begin
      goto(g + 2 + 2 * i);
      done_bit_in = 1'b1;
      #1;
      chk("done_bit_owner", own ? a_s1_done_bit : a_s0_done_bit, 1'b1);
      chk("done_bit_other", own ? a_s0_done_bit : a_s1_done_bit, 1'b0);
      step(1);
      done_bit_in = 1'b0;
    end
    goto(g + 30);
    done_dz_in = 1'b1;
    #1;
    chk("done_dz_owner", own ? a_s1_done_dz : a_s0_done_dz, 1'b1);
    step(1);
    done_dz_in = 1'b0;
    chk("busy_after", a_busy, 1'b0);
    chk("valid_after", a_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; frame_en = 1'b0; clr_err = 1'b0;
    s0_led_data = 24'h112233; s0_valid = 1'b1; s0_start = 1'b1;
    s1_req = 1'b0; s1_led_data = 24'haabbcc; s1_valid = 1'b1; s1_start = 1'b0;
    done_bit_in = 1'b0; done_dz_in = 1'b0;
    step(3);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_owner", a_owner, 1'b0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data", a_led_data, 24'h0);
    chk("rst_ovr", a_overrun_cnt, 8'd0);
    chk("rst_errs", {a_err_timeout, a_err_len}, 2'b00);
    chk("rst_b_out", {b_valid, b_start, b_led_data}, 26'h0);
    rst_n = 1'b1; frame_en = 1'b1;

    // first grant lands one cycle after the first wrap
    wait_stb(n); g = cyc;
    chk("first_grant_gap", n, 100);
    chk("f1_stb", {a_s0_frame_stb, a_s1_frame_stb}, 2'b10);
    chk("f1_grant_busy", a_busy, 1'b1);
    chk("f1_grant_valid", a_valid, 1'b0);
    run_frame(1'b0, 4, 24'h112233, 1'b1);
    chk("f1_errs", {a_err_timeout, a_err_len}, 2'b00);

    wait_stb(n); g = cyc;
    chk("f2_grant_gap", n, 69);
    run_frame(1'b0, 3, 24'h112233, 1'b1);
    chk("short_len_err", a_err_len, 1'b1);
    pulse_clr();
    chk("short_len_clr", a_err_len, 1'b0);

    wait_stb(n); g = cyc;
    chk("f3_grant_gap", n, 68);
    run_frame(1'b0, 5, 24'h112233, 1'b1);
    chk("long_len_err", a_err_len, 1'b1);
    pulse_clr();
    s1_req = 1'b1;

    // overlay source takes the slot; the no-priority instance still serves source 0
    wait_stb(n); g = cyc;
    chk("f4_grant_gap", n, 68);
    chk("s1_stb", {a_s0_frame_stb, a_s1_frame_stb}, 2'b01);
    chk("s1_owner", a_owner, 1'b1);
    chk("nopri_stb", {b_s0_frame_stb, b_s1_frame_stb}, 2'b10);
    s1_req = 1'b0;
    run_frame(1'b1, 4, 24'haabbcc, 1'b0);
    chk("exact_len_ok", a_err_len, 1'b0);

    // no completion: timeout
    wait_stb(n); g = cyc;
    chk("f5_grant_gap", n, 69);
    goto(g + 59);
    chk("to_pre_busy", a_busy, 1'b1);
    chk("to_pre_valid", a_valid, 1'b1);
    step(1);
    chk("to_cycle_valid", a_valid, 1'b0);
    chk("to_cycle_err", a_err_timeout, 1'b0);
    step(1);
    chk("to_err", a_err_timeout, 1'b1);
    chk("to_busy", a_busy, 1'b0);
    chk("b_still_busy", b_busy, 1'b1);
    goto(g + 100);
    chk("grant_after_to", a_s0_frame_stb, 1'b1);
    chk("b_overrun_one", b_overrun_cnt, 8'd1);
    goto(g + 150);
    done_dz_in = 1'b1;
    #1;
    chk("b_late_dz_routed", b_s0_done_dz, 1'b1);
    step(1);
    done_dz_in = 1'b0;
    chk("b_late_busy", b_busy, 1'b0);
    chk("b_late_no_to", b_err_timeout, 1'b0);
    chk("a_zero_pix_len", a_err_len, 1'b1);
    pulse_clr();
    chk("clr_to", a_err_timeout, 1'b0);
    chk("clr_len", a_err_len, 1'b0);
    chk("clr_ovr", b_overrun_cnt, 8'd0);

    wait_stb(n); g = cyc;
    chk("f7_grant_gap", n, 48);
    // a times out again at g+160 while clr_err is high
    goto(g + 160);
    pulse_clr();
    chk("err_beats_clr", a_err_timeout, 1'b1);
    goto(g + 200);
    chk("b_ovr_after_clr", b_overrun_cnt, 8'd1);
    step(1);
    chk("b_timeout", b_err_timeout, 1'b1);
    goto(g + 400);
    chk("b_ovr_two", b_overrun_cnt, 8'd2);
    goto(g + 499);
    pulse_clr();
    chk("ovr_clr_same_cycle", b_overrun_cnt, 8'd1);

    step(46000);
    chk("ovr_saturate", b_overrun_cnt, 8'd255);
    chk("a_never_overran", a_overrun_cnt, 8'd0);

    // reset in the middle of an overlay frame
    s1_req = 1'b1;
    wait_stb(n);
    chk("pre_rst_grant_found", n <= 100, 1'b1);
    s1_req = 1'b0;
    step(5);
    chk("pre_rst_data", a_led_data, 24'haabbcc);
    chk("pre_rst_owner", a_owner, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_drv", {a_valid, a_start, a_led_data}, 26'h0);
    chk("async_rst_state", {a_busy, a_owner, a_err_timeout, a_err_len}, 4'h0);
    chk("async_rst_ovr", b_overrun_cnt, 8'd0);
    step(2);
    rst_n = 1'b1;
    wait_stb(n);
    chk("post_rst_grant_gap", n, 100);
    chk("post_rst_stb", {a_s0_frame_stb, a_s1_frame_stb}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
